// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: start, 8 data bits LSB first, even parity, stop.
// Delivers each byte with a valid/ack handshake plus parity, framing and overrun flags.
module uart_rx_frame #(
  parameter int unsigned CYCLES_PER_BIT = 16
) (
  input  logic       i_clk_sis,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_data_ack,
  output logic [7:0] o_data_out,
  output logic       o_data_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned HALF_BIT = CYCLES_PER_BIT / 2;
  localparam int unsigned CW       = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHi
  } state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cyc;
  logic [2:0]    r_nbit;
  logic [7:0]    r_sh;
  logic          r_par;

  logic w_rx_s;
  logic w_bit_end;
  logic w_half;
  logic w_shift;
  logic w_cap_par;
  logic w_publish;
  logic w_acked;

  assign w_rx_s  = r_sync2;
  assign w_acked = o_data_valid & i_data_ack;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge i_clk_sis) begin
    if (!i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk_sis) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (!w_rx_s) w_state_next = StStart;
      StStart:  if (w_half) w_state_next = w_rx_s ? StIdle : StData;
      StData:   if (w_bit_end && (r_nbit == 3'd7)) w_state_next = StParity;
      StParity: if (w_bit_end) w_state_next = StStop;
      StStop:   if (w_bit_end) w_state_next = w_rx_s ? StIdle : StWaitHi;
      StWaitHi: if (w_rx_s) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // FSM outputs: sample strobes and busy.
  always_comb begin
    w_bit_end = (r_cyc == CYC_LAST);
    w_half    = (r_state == StStart) && (r_cyc == CYC_HALF);
    w_shift   = (r_state == StData) && w_bit_end;
    w_cap_par = (r_state == StParity) && w_bit_end;
    w_publish = (r_state == StStop) && w_bit_end;
    o_busy    = (r_state != StIdle);
  end

  // Bit-period counter restarts on every state change and on each data sample.
  always_ff @(posedge i_clk_sis) begin
    if (!i_rst) begin
      r_cyc <= '0;
    end else if ((w_state_next != r_state) || w_shift) begin
      r_cyc <= '0;
    end else if (r_state != StIdle) begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  // Data shift register, bit counter and parity capture.
  always_ff @(posedge i_clk_sis) begin
    if (!i_rst) begin
      r_nbit <= '0;
      r_sh   <= '0;
      r_par  <= 1'b0;
    end else begin
      if (r_state == StStart) begin
        r_nbit <= '0;
      end else if (w_shift) begin
        r_nbit <= r_nbit + 1'b1;
      end
      if (w_shift) begin
        r_sh <= {w_rx_s, r_sh[7:1]};
      end
      if (w_cap_par) begin
        r_par <= w_rx_s ^ (^r_sh);
      end
    end
  end

  // Output holding register: publish, drop-on-overrun and ack handshake.
  always_ff @(posedge i_clk_sis) begin
    if (!i_rst) begin
      o_data_out   <= 8'h00;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (w_publish && (!o_data_valid || i_data_ack)) begin
        o_data_out   <= r_sh;
        o_parity_err <= r_par;
        o_frame_err  <= ~w_rx_s;
        o_data_valid <= 1'b1;
      end else if (w_acked) begin
        o_data_valid <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
      end
      // Ack wins over a simultaneous drop because a drop requires no ack.
      if (w_acked) begin
        o_overrun <= 1'b0;
      end else if (w_publish && o_data_valid) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized bench for uart_rx_frame against a frame-level reference model.
module tb_uart_rx_frame;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int PUB  = 2 + HALF + 10 * CPB + 1;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_total;
  int n_bad;

  // Reference model of the parallel side.
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_perr;
  logic       m_ferr;
  logic       m_ovr;

  uart_rx_frame #(
    .CYCLES_PER_BIT(CPB)
  ) u_dut (
    .i_clk_sis   (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .i_data_ack  (ack),
    .o_data_out  (data_out),
    .o_data_valid(data_valid),
    .o_parity_err(parity_err),
    .o_frame_err (frame_err),
    .o_overrun   (overrun),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx  = 1'b1;
    ack = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_publish(input logic [7:0] d, input logic pbit, input logic stopb,
                               input logic ack_pub);
    if (!m_valid || ack_pub) begin
      if (m_valid) m_ovr = 1'b0;
      m_data  = d;
      m_perr  = (pbit != ^d);
      m_ferr  = !stopb;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(data_out), 32'(m_data));
    check({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
    check({tag, ".perr"}, 32'(parity_err), 32'(m_perr));
    check({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    model_ack();
  endtask

  // Drives one 11-bit frame; ack_at / rst_at pulse ack / reset before that tick.
  // lat returns the tick count from the falling start edge to data_valid rising.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input int ack_at, input int rst_at, output int lat);
    logic [10:0] bits;
    logic        prev;
    bits = {stopb, pbit, d, 1'b0};
    lat  = -1;
    for (int t = 0; t < 11 * CPB; t++) begin
      rx   = bits[t / CPB];
      ack  = (t == ack_at);
      rst  = (t == rst_at) ? 1'b0 : 1'b1;
      prev = data_valid;
      tick();
      if (!prev && data_valid && (lat < 0)) lat = t + 1;
      if (t == rst_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;
        return;
      end
    end
    ack = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic pbit,
                       input logic stopb, input logic ack_pub);
    int  lat;
    logic was_valid;
    was_valid = m_valid;
    send_frame(d, pbit, stopb, ack_pub ? PUB - 1 : -1, -1, lat);
    model_publish(d, pbit, stopb, ack_pub);
    if (!was_valid) check({tag, ".lat"}, 32'(lat), 32'(PUB));
  endtask

  initial begin
    int lat;
    n_total = 0;
    n_bad   = 0;
    model_reset();
    rst = 1'b0;
    rx  = 1'b1;
    ack = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    check_all("reset");
    check("reset.busy", 32'(busy), 32'd0);

    // Clean byte, then ack clears valid on the next cycle.
    frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    idle(3);
    check_all("a5");
    do_ack();
    check_all("a5.ack");

    // Wrong parity bit.
    frame("par", 8'h01, 1'b0, 1'b1, 1'b0);
    idle(3);
    check_all("par");
    do_ack();

    // Framing error followed by a held break.
    frame("brk", 8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("brk.busy_hi", 32'(busy), 32'd1);
    check_all("brk");
    rx = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("brk.busy_lo", 32'(busy), 32'd0);
    idle(200);
    check_all("brk.nospur");
    do_ack();

    // Short glitch on an idle line aborts in START.
    rx = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rx = 1'b1;
    for (int i = 0; i < HALF + 3 - 4; i++) tick();
    check("glitch.busy", 32'(busy), 32'd0);
    check_all("glitch");
    idle(20);

    // Overrun: second frame dropped, ack clears both.
    frame("ovr1", 8'h11, 1'b0, 1'b1, 1'b0);
    idle(5);
    frame("ovr2", 8'h22, 1'b0, 1'b1, 1'b0);
    idle(3);
    check_all("ovr");
    do_ack();
    check_all("ovr.ack");

    // Ack in the publish cycle reloads instead of dropping.
    frame("rl1", 8'h11, 1'b0, 1'b1, 1'b0);
    idle(5);
    frame("rl2", 8'h22, 1'b0, 1'b1, 1'b1);
    idle(3);
    check_all("reload");
    do_ack();

    // Reset in the middle of the data bits, then a clean frame.
    send_frame(8'h5A, 1'b0, 1'b1, -1, 5 * CPB + HALF, lat);
    model_reset();
    check_all("rst_mid");
    check("rst_mid.busy", 32'(busy), 32'd0);
    idle(20);
    frame("f0", 8'hF0, 1'b0, 1'b1, 1'b0);
    idle(3);
    check_all("f0");
    do_ack();

    // Randomized frames with random errors and ack placement.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       pbit;
      logic       stopb;
      logic       ack_pub;
      d       = 8'($urandom);
      pbit    = ($urandom_range(3) == 0) ? !(^d) : ^d;
      stopb   = ($urandom_range(7) != 0);
      ack_pub = ($urandom_range(3) == 0);
      frame("rnd", d, pbit, stopb, ack_pub);
      idle(4 + $urandom_range(16));
      check_all("rnd");
      check("rnd.busy", 32'(busy), 32'd0);
      if ($urandom_range(1) == 1) begin
        do_ack();
        check_all("rnd.ack");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
